// File: rtl/hpdcache_sram_rsp_buf_pkg.sv
// Shared helpers for the SRAM response buffer.
// Provides index-width sizing used by the top and its FIFO.
package hpdcache_sram_rsp_buf_pkg;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpdcache_sram_rsp_fifo.sv
// Register FIFO of {id, data} read responses.
// Ports: push_i/wdata_i, pop_i/rdata_o, full_o, empty_o, occ_o.
module hpdcache_sram_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PTR_W = 1,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] occ_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  // With one entry both pointers stay on slot 0.
  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push_i) wptr_d = nxt(wptr_q);
    if (pop_i)  rptr_d = nxt(rptr_q);
    if (push_i && !pop_i) occ_d = occ_q + CNT_W'(1);
    if (!push_i && pop_i) occ_d = occ_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Storage is data only; validity lives in occ_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == CNT_W'(DEPTH));
  assign occ_o   = occ_q;

endmodule

// File: rtl/hpdcache_sram_rsp_buf.sv
// SRAM front-end: drives the macro and returns tagged read data.
// Ports: req_* in, sram_* macro side, rsp_* out, busy_o.
module hpdcache_sram_rsp_buf
  import hpdcache_sram_rsp_buf_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 0,
  parameter int unsigned DATA_SIZE = 0,
  parameter int unsigned NDATA     = 1,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [ADDR_SIZE-1:0]       req_addr_i,
  input  logic [NDATA*DATA_SIZE-1:0] req_wdata_i,
  input  logic [ID_W-1:0]            req_id_i,
  output logic                       sram_cs_o,
  output logic                       sram_we_o,
  output logic [ADDR_SIZE-1:0]       sram_addr_o,
  output logic [NDATA*DATA_SIZE-1:0] sram_wdata_o,
  input  logic [NDATA*DATA_SIZE-1:0] sram_rdata_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [NDATA*DATA_SIZE-1:0] rsp_rdata_o,
  output logic [ID_W-1:0]            rsp_id_o,
  output logic                       busy_o
);

  localparam int unsigned DW    = NDATA * DATA_SIZE;
  localparam int unsigned EW    = ID_W + DW;
  localparam int unsigned PTR_W = idx_w(RSP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  logic            acc;
  logic            rd_pend_q, rd_pend_d;
  logic [ID_W-1:0] pend_id_q, pend_id_d;
  logic            push, pop;
  logic            full, empty;
  logic [CNT_W-1:0] occ;
  logic [EW-1:0]   head;
  logic [CNT_W:0]  used;

  // No credit for a same-cycle pop keeps ready off the rsp path.
  assign used = {1'b0, occ} + {{CNT_W{1'b0}}, rd_pend_q};
  assign req_ready_o = rst_n & (used < (CNT_W+1)'(RSP_DEPTH));
  assign acc = req_valid_i & req_ready_o;

  assign sram_cs_o    = acc;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;

  always_comb begin
    rd_pend_d = acc & ~req_we_i;
    pend_id_d = pend_id_q;
    if (acc && !req_we_i) pend_id_d = req_id_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      pend_id_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      pend_id_q <= pend_id_d;
    end
  end

  // rdata lives one cycle: keep it unless the bypass takes it now.
  assign push = rd_pend_q & ~(empty & rsp_ready_i);
  assign pop  = ~empty & rsp_ready_i;

  hpdcache_sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (EW),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({pend_id_q, sram_rdata_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .occ_o   (occ)
  );

  assign rsp_valid_o = rst_n & (~empty | rd_pend_q);
  assign rsp_rdata_o = empty ? sram_rdata_i : head[DW-1:0];
  assign rsp_id_o    = empty ? pend_id_q : head[EW-1:DW];
  assign busy_o      = rst_n & (rd_pend_q | ~empty);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: tb/tb_hpdcache_sram_rsp_buf.sv
// Directed bench for hpdcache_sram_rsp_buf.
// Includes a behavioural single-port SRAM macro.
module tb_hpdcache_sram_rsp_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_i, req_ready_o, req_we_i;
  logic [3:0] req_addr_i;
  logic [7:0] req_wdata_i;
  logic [3:0] req_id_i;
  logic       sram_cs_o, sram_we_o;
  logic [3:0] sram_addr_o;
  logic [7:0] sram_wdata_o, sram_rdata_i;
  logic       rsp_valid_o, rsp_ready_i;
  logic [7:0] rsp_rdata_o;
  logic [3:0] rsp_id_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cs_o) begin
      if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
      else sram_rdata_i <= mem[sram_addr_o];
    end
  end

  hpdcache_sram_rsp_buf #(
    .ADDR_SIZE (4),
    .DATA_SIZE (8),
    .NDATA     (1),
    .ID_W      (4),
    .RSP_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_id_i     (req_id_i),
    .sram_cs_o    (sram_cs_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_id_o     (rsp_id_o),
    .busy_o       (busy_o)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = 1'b1;
    req_we_i = 1'b0;
    req_addr_i = 4'd0;
    req_wdata_i = 8'd0;
    req_id_i = 4'd0;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if ({sram_cs_o, rsp_valid_o, req_ready_o, busy_o} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_outs cyc%0d got cs/v/rdy/busy=%b want 0000",
                 c, {sram_cs_o, rsp_valid_o, req_ready_o, busy_o});
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({req_ready_o, sram_cs_o} !== 2'b11) begin
      fails++;
      $display("FAIL reset_first_acc got rdy/cs=%b want 11",
               {req_ready_o, sram_cs_o});
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({rsp_valid_o, rsp_id_o, rsp_rdata_o} !== {1'b1, 4'd0, 8'h00}) begin
      fails++;
      $display("FAIL reset_first_rsp got v=%b id=%h d=%h want 1 0 00",
               rsp_valid_o, rsp_id_o, rsp_rdata_o);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({rsp_valid_o, busy_o} !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle got v/busy=%b want 00", {rsp_valid_o, busy_o});
    end
  endtask

  task automatic test_write_read();
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_we_i = 1'b1;
    req_addr_i = 4'd3;
    req_wdata_i = 8'hA5;
    req_id_i = 4'd1;
    @(negedge clk);
    tests++;
    if ({req_ready_o, sram_cs_o, sram_we_o} !== 3'b111) begin
      fails++;
      $display("FAIL wr_accept got rdy/cs/we=%b want 111",
               {req_ready_o, sram_cs_o, sram_we_o});
    end
    @(posedge clk);
    #1;
    req_we_i = 1'b0;
    req_id_i = 4'd2;
    @(negedge clk);
    tests++;
    if ({sram_cs_o, rsp_valid_o} !== 2'b10) begin
      fails++;
      $display("FAIL wr_no_rsp got cs/v=%b want 10", {sram_cs_o, rsp_valid_o});
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({rsp_valid_o, rsp_id_o, rsp_rdata_o} !== {1'b1, 4'd2, 8'hA5}) begin
      fails++;
      $display("FAIL wr_rd_rsp got v=%b id=%h d=%h want 1 2 a5",
               rsp_valid_o, rsp_id_o, rsp_rdata_o);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({rsp_valid_o, busy_o} !== 2'b00) begin
      fails++;
      $display("FAIL wr_rd_single got v/busy=%b want 00",
               {rsp_valid_o, busy_o});
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk);
      #1;
      req_valid_i = (i < 8);
      req_we_i = 1'b0;
      req_addr_i = 4'(i);
      req_id_i = 4'(i);
      @(negedge clk);
      if (i < 8) begin
        tests++;
        if (req_ready_o !== 1'b1) begin
          fails++;
          $display("FAIL stream_ready i=%0d got %b want 1", i, req_ready_o);
        end
      end
      if (i > 0) begin
        tests++;
        if ({rsp_valid_o, rsp_id_o, rsp_rdata_o} !==
            {1'b1, 4'(i - 1), 8'h10 + 8'(i - 1)}) begin
          fails++;
          $display("FAIL stream_rsp n=%0d got v=%b id=%h d=%h want 1 %h %h",
                   i - 1, rsp_valid_o, rsp_id_o, rsp_rdata_o,
                   4'(i - 1), 8'h10 + 8'(i - 1));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (rsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL stream_end got v=%b want 0", rsp_valid_o);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    int cyc = 0;
    for (int i = 0; i < 4; i++) mem[8 + i] = 8'h80 + 8'(i);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b0;
      req_valid_i = (idx < 4);
      req_we_i = 1'b0;
      req_addr_i = 4'(8 + idx);
      req_id_i = 4'(8 + idx);
      @(negedge clk);
      if (req_valid_i && req_ready_o) idx++;
      if (c > 0) begin
        tests++;
        if ({rsp_valid_o, rsp_id_o, rsp_rdata_o} !== {1'b1, 4'd8, 8'h80}) begin
          fails++;
          $display("FAIL bp_stable c=%0d got v=%b id=%h d=%h want 1 8 80",
                   c, rsp_valid_o, rsp_id_o, rsp_rdata_o);
        end
      end
    end
    tests++;
    if (idx !== 2 || req_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL bp_accepts got acc=%0d rdy=%b want 2 0", idx, req_ready_o);
    end
    while (got < 4 && cyc < 20) begin
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b1;
      req_valid_i = (idx < 4);
      req_addr_i = 4'(8 + idx);
      req_id_i = 4'(8 + idx);
      @(negedge clk);
      if (req_valid_i && req_ready_o) idx++;
      if (rsp_valid_o) begin
        tests++;
        if ({rsp_id_o, rsp_rdata_o} !== {4'(8 + got), 8'h80 + 8'(got)}) begin
          fails++;
          $display("FAIL bp_order n=%0d got id=%h d=%h want %h %h", got,
                   rsp_id_o, rsp_rdata_o, 4'(8 + got), 8'h80 + 8'(got));
        end
        got++;
      end
      cyc++;
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    tests++;
    if (got !== 4 || idx !== 4) begin
      fails++;
      $display("FAIL bp_drain got rsp=%0d acc=%0d want 4 4", got, idx);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass_not_taken();
    int hs = 0;
    mem[5] = 8'h55;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i = 1'b0;
    req_addr_i = 4'd5;
    req_id_i = 4'd5;
    @(negedge clk);
    tests++;
    if (sram_cs_o !== 1'b1) begin
      fails++;
      $display("FAIL bnt_accept got cs=%b want 1", sram_cs_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      rsp_ready_i = (c > 0);
      @(negedge clk);
      if (rsp_valid_o && rsp_ready_i) hs++;
      if (c < 2) begin
        tests++;
        if ({rsp_valid_o, rsp_id_o, rsp_rdata_o} !== {1'b1, 4'd5, 8'h55}) begin
          fails++;
          $display("FAIL bnt_rsp c=%0d got v=%b id=%h d=%h want 1 5 55",
                   c, rsp_valid_o, rsp_id_o, rsp_rdata_o);
        end
      end
    end
    tests++;
    if (hs !== 1 || dut.occ !== 2'd0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL bnt_single got hs=%0d occ=%0d busy=%b want 1 0 0",
               hs, dut.occ, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    mem[6] = 8'h66;
    mem[7] = 8'h77;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1;
      req_we_i = 1'b0;
      req_addr_i = 4'(6 + i);
      req_id_i = 4'(6 + i);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if (dut.occ !== 2'd1 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL mid_setup got occ=%0d busy=%b want 1 1", dut.occ, busy_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({rsp_valid_o, req_ready_o, busy_o} !== 3'b000) begin
      fails++;
      $display("FAIL mid_in_reset got v/rdy/busy=%b want 000",
               {rsp_valid_o, req_ready_o, busy_o});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid_o, busy_o} !== 2'b00) begin
        fails++;
        $display("FAIL mid_stale c=%0d got v/busy=%b want 00",
                 c, {rsp_valid_o, busy_o});
      end
      @(posedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    sram_rdata_i = 8'h00;
    test_reset();
    test_write_read();
    test_streaming();
    test_backpressure();
    test_bypass_not_taken();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hpdcache_sram_rsp_buf.md
# hpdcache_sram_rsp_buf

SRAM access front-end that sits directly upstream of the single-port SRAM macro and consumes its registered read data. Accepts read/write requests on a valid/ready channel, drives the macro's chip-select/write-enable/address/data in the accept cycle, and returns read data with the request tag on a valid/ready response channel. A small response FIFO absorbs downstream backpressure. Credit gating ensures read data is never lost, since the macro's `rdata` is only valid for the single cycle after a read.

## Interface
Parameters:
- `ADDR_SIZE`, 0: SRAM address width; must be ≥1.
- `DATA_SIZE`, 0: SRAM word width.
- `NDATA`, 1: words per SRAM row.
- `ID_W`, 4: request/response tag width.
- `RSP_DEPTH`, 2: response FIFO entries; must be ≥1; 2 gives full throughput.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all state updates on posedge.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request ready; does not depend on `req_valid_i`.
- `req_we_i`, in, 1: 1 = write, 0 = read.
- `req_addr_i`, in, ADDR_SIZE: row address.
- `req_wdata_i`, in, NDATA×DATA_SIZE: write data.
- `req_id_i`, in, ID_W: tag echoed on the read response.
- `sram_cs_o`, out, 1: macro chip select.
- `sram_we_o`, out, 1: macro write enable.
- `sram_addr_o`, out, ADDR_SIZE: macro address.
- `sram_wdata_o`, out, NDATA×DATA_SIZE: macro write data.
- `sram_rdata_i`, in, NDATA×DATA_SIZE: macro read data; valid only in the cycle after a read.
- `rsp_valid_o`, out, 1: read response valid.
- `rsp_ready_i`, in, 1: read response ready.
- `rsp_rdata_o`, out, NDATA×DATA_SIZE: response data.
- `rsp_id_o`, out, ID_W: response tag.
- `busy_o`, out, 1: read pending or FIFO non-empty.

## Operation
- Accept: `acc = req_valid_i & req_ready_o`.
- `req_ready_o = rst_n & (occ + rd_pend < RSP_DEPTH)`.
  - Credit check is conservative: no same-cycle pop credit.
  - Applies to writes too.
- SRAM drive is combinational from the request:
  - `sram_cs_o = acc`, `sram_we_o = req_we_i`.
  - `sram_addr_o`/`sram_wdata_o` pass `req_addr_i`/`req_wdata_i` through.
- Writes produce no response.
- A read accepted at cycle T sets `rd_pend` and `pend_id <= req_id_i` for cycle T+1.
  - `rd_pend` clears at T+1 unless another read is accepted at T+1.
- Response source selection:
  - FIFO non-empty: head entry.
  - FIFO empty and `rd_pend = 1`: bypass `sram_rdata_i`/`pend_id`.
  - Otherwise `rsp_valid_o = 0`.
- At T+1 with `rd_pend = 1`:
  - If the bypass is presented and `rsp_ready_i = 1`: consumed, not stored.
  - Otherwise `sram_rdata_i`/`pend_id` are pushed to the FIFO tail.
- Pop: FIFO non-empty and `rsp_ready_i = 1`. Simultaneous push and pop are legal; `occ` is unchanged.
- Responses return in request order.
- Pointers are `$clog2(RSP_DEPTH)` bits wide and wrap from `RSP_DEPTH-1` to 0; a one-entry FIFO uses a fixed slot.
- `occ` is `$clog2(RSP_DEPTH+1)` bits wide.
- Push is never attempted while full (guaranteed by credits). An assertion flags overflow, and flags pop while empty.
- Reset (synchronous, `rst_n = 0` at a posedge):
  - `rd_pend = 0`, `occ = 0`, pointers = 0.
  - `rsp_valid_o = 0`, `busy_o = 0`, `sram_cs_o = 0`, `req_ready_o = 0` while asserted.
  - Pending read data and FIFO contents are discarded.
  - First accept is possible in the cycle `rst_n` is high.
- FIFO entries are not reset; only the control state is.

## Timing
- Read latency: accept at T leads to `rsp_valid_o` at T+1 via the bypass when the FIFO is empty; otherwise it queues behind older entries.
- Throughput: one request per cycle sustained when `RSP_DEPTH ≥ 2` and `rsp_ready_i = 1`.
- With `RSP_DEPTH = 1`, back-to-back reads get one accept every 2 cycles.
- Under backpressure, `req_ready_o` drops once `occ + rd_pend = RSP_DEPTH`.
- Response handshake rule: once `rsp_valid_o = 1`, valid, data and tag stay stable until `rsp_ready_i`. This holds because a bypass that is not consumed is pushed and shown again from the head.
- Write followed by a read of the same address in the next cycle returns the new data; the macro orders them.

## Structure
- No shared-package types; all widths derive from parameters.
- Localparams `PTR_W` and `CNT_W` are defined in the module.
- One sub-module, `hpdcache_sram_rsp_fifo`:
  - Register FIFO of {id, data}, parameterized depth and width.
  - Ports: push, pop, full, empty, occupancy.
- The top level holds the credit logic, the `rd_pend`/`pend_id` register, the bypass mux and the assertions.

## Test plan
- Reset: hold `rst_n = 0` 3 cycles with `req_valid_i = 1`.
  - Required: `sram_cs_o = 0`, `rsp_valid_o = 0`, `req_ready_o = 0`, `busy_o = 0`.
  - First accept in the cycle after release.
- Write then read: write 0xA5 to addr 3 (id 1), read addr 3 (id 2), `rsp_ready_i = 1`.
  - Required: one response, data 0xA5, id 2, exactly 1 cycle after the read accept.
- Streaming: 8 back-to-back reads, ids 0–7, `rsp_ready_i = 1`.
  - Required: `req_ready_o` stays 1; responses on 8 consecutive cycles in id order.
- Backpressure: `rsp_ready_i = 0` while issuing 4 reads.
  - Required: exactly 2 accepted (`RSP_DEPTH = 2`), `req_ready_o = 0`, response data/id stable.
  - Raise `rsp_ready_i`: both drain in order, then the remaining reads are accepted.
- Bypass not taken: read with `rsp_ready_i` low in the data cycle, high next cycle.
  - Required: same data/id shown on both cycles, a single handshake, `occ` returns to 0.
- Reset mid-operation: assert `rst_n = 0` with 1 read pending and 1 queued entry.
  - Required: after release, no stale response ever appears and `busy_o = 0`.
